// File: rtl/cam_mgr_pkg.sv
// Shared types for the CAM table manager: request op codes, response status
// codes and the control FSM state encoding.
package cam_mgr_pkg;

  typedef enum logic [1:0] {
    OP_INSERT = 2'd0,
    OP_DELETE = 2'd1,
    OP_LOOKUP = 2'd2,
    OP_RSVD   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_OK       = 2'd0,
    ST_EXISTS   = 2'd1,
    ST_NOTFOUND = 2'd2,
    ST_FULL     = 2'd3
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_DECIDE    = 3'd2,
    S_WRITE     = 3'd3,
    S_WAIT_BUSY = 3'd4,
    S_RESP      = 3'd5
  } state_e;

endpackage

// File: rtl/cam_free_alloc.sv
// Free-slot tracker: bitmap of unused CAM addresses, lowest-free priority
// encoder and a running free-slot count kept in step with the bitmap.
module cam_free_alloc #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_i,
  input  logic                  release_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [ADDR_WIDTH-1:0] alloc_addr_o,
  output logic [ADDR_WIDTH:0]   free_count_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE        = (ADDR_WIDTH + 1)'(1);

  logic [DEPTH-1:0]    map_q, map_d;
  logic [ADDR_WIDTH:0] count_q, count_d;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      localparam logic [ADDR_WIDTH-1:0] SLOT = ADDR_WIDTH'(gi);
      assign map_d[gi] = (release_i && addr_i == SLOT) ? 1'b1 :
                         (alloc_i   && addr_i == SLOT) ? 1'b0 : map_q[gi];
    end
  endgenerate

  // Alloc and release are never asserted together, so a +/-1 keeps the
  // count equal to the popcount of the bitmap.
  always_comb begin
    count_d = count_q;
    if (alloc_i) begin
      count_d = count_q - ONE;
    end else if (release_i) begin
      count_d = count_q + ONE;
    end
  end

  always_comb begin
    logic found;
    found        = 1'b0;
    alloc_addr_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (map_q[i] && !found) begin
        alloc_addr_o = ADDR_WIDTH'(i);
        found        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      map_q   <= '1;
      count_q <= FULL_COUNT;
    end else begin
      map_q   <= map_d;
      count_q <= count_d;
    end
  end

  assign free_count_o = count_q;

endmodule

// File: rtl/cam_table_mgr.sv
// Single-requester table manager in front of the SRL CAM: serialises
// insert/delete/lookup, owns the CAM write and compare ports, allocates slots.
module cam_table_mgr
  import cam_mgr_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 5,
  parameter int CMP_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [DATA_WIDTH-1:0] req_key,
  output logic                  resp_valid,
  output logic [1:0]            resp_status,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  output logic [ADDR_WIDTH:0]   free_count,
  output logic [ADDR_WIDTH-1:0] cam_write_addr,
  output logic [DATA_WIDTH-1:0] cam_write_data,
  output logic                  cam_write_delete,
  output logic                  cam_write_enable,
  input  logic                  cam_write_busy,
  output logic [DATA_WIDTH-1:0] cam_compare_data,
  input  logic                  cam_match,
  input  logic [ADDR_WIDTH-1:0] cam_match_addr
);

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  status_e               status_q, status_d;
  logic [DATA_WIDTH-1:0] key_q, key_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  match_q, match_d;
  logic [ADDR_WIDTH-1:0] match_addr_q, match_addr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  guard_q, guard_d;
  logic                  ready_c;
  logic                  alloc_c, release_c;
  logic [ADDR_WIDTH-1:0] alloc_addr;

  assign alloc_c   = (state_q == S_WRITE) && (op_q == OP_INSERT);
  assign release_c = (state_q == S_WRITE) && (op_q == OP_DELETE);

  cam_free_alloc #(.ADDR_WIDTH(ADDR_WIDTH)) u_free_alloc (
    .clk          (clk),
    .rst          (rst),
    .alloc_i      (alloc_c),
    .release_i    (release_c),
    .addr_i       (addr_q),
    .alloc_addr_o (alloc_addr),
    .free_count_o (free_count)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    status_d     = status_q;
    key_d        = key_q;
    cnt_d        = cnt_q;
    match_d      = match_q;
    match_addr_d = match_addr_q;
    addr_d       = addr_q;
    guard_d      = guard_q;
    ready_c      = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready_c = !cam_write_busy;
        if (req_valid && ready_c) begin
          op_d    = op_e'(req_op);
          key_d   = req_key;
          cnt_d   = 3'(CMP_LATENCY);
          state_d = S_LOOKUP;
        end
      end
      // The counter starts at CMP_LATENCY while compare data first appears,
      // so sampling at zero lands on the cycle the CAM result is valid.
      S_LOOKUP: begin
        if (cnt_q == 3'd0) begin
          match_d      = cam_match;
          match_addr_d = cam_match_addr;
          state_d      = S_DECIDE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_DECIDE: begin
        status_d = ST_OK;
        addr_d   = '0;
        state_d  = S_RESP;
        case (op_q)
          OP_INSERT: begin
            if (match_q) begin
              status_d = ST_EXISTS;
              addr_d   = match_addr_q;
            end else if (free_count == '0) begin
              status_d = ST_FULL;
            end else begin
              addr_d  = alloc_addr;
              state_d = S_WRITE;
            end
          end
          OP_DELETE: begin
            if (match_q) begin
              addr_d  = match_addr_q;
              state_d = S_WRITE;
            end else begin
              status_d = ST_NOTFOUND;
            end
          end
          default: begin
            status_d = match_q ? ST_OK : ST_NOTFOUND;
            addr_d   = match_q ? match_addr_q : '0;
          end
        endcase
      end
      S_WRITE: begin
        guard_d = 1'b1;
        state_d = S_WAIT_BUSY;
      end
      // Busy may not rise until the cycle after the write pulse; skip that one.
      S_WAIT_BUSY: begin
        if (guard_q) begin
          guard_d = 1'b0;
        end else if (!cam_write_busy) begin
          status_d = ST_OK;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= OP_INSERT;
      status_q     <= ST_OK;
      key_q        <= '0;
      cnt_q        <= '0;
      match_q      <= 1'b0;
      match_addr_q <= '0;
      addr_q       <= '0;
      guard_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      status_q     <= status_d;
      key_q        <= key_d;
      cnt_q        <= cnt_d;
      match_q      <= match_d;
      match_addr_q <= match_addr_d;
      addr_q       <= addr_d;
      guard_q      <= guard_d;
    end
  end

  assign req_ready        = ready_c && !rst;
  assign resp_valid       = (state_q == S_RESP) && !rst;
  assign resp_status      = resp_valid ? status_q : ST_OK;
  assign resp_addr        = resp_valid ? addr_q : '0;
  assign cam_write_enable = (state_q == S_WRITE) && !rst;
  assign cam_write_addr   = cam_write_enable ? addr_q : '0;
  assign cam_write_data   = cam_write_enable ? key_q : '0;
  assign cam_write_delete = cam_write_enable && (op_q == OP_DELETE);
  assign cam_compare_data = ((state_q != S_IDLE) && !rst) ? key_q : '0;

endmodule

// File: tb/tb_cam_table_mgr.sv
// Scoreboard bench for cam_table_mgr with a behavioural CAM model attached
// to its write/compare ports and a programmable write-busy duration.
module tb_cam_table_mgr;

  localparam int DW    = 64;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  localparam logic [1:0] INS = 2'd0, DEL = 2'd1, LKP = 2'd2, RSV = 2'd3;
  localparam logic [1:0] OK = 2'd0, EXISTS = 2'd1, NOTFOUND = 2'd2, FULL = 2'd3;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [DW-1:0] req_key;
  logic          resp_valid;
  logic [1:0]    resp_status;
  logic [AW-1:0] resp_addr;
  logic [AW:0]   free_count;
  logic [AW-1:0] cam_write_addr;
  logic [DW-1:0] cam_write_data;
  logic          cam_write_delete;
  logic          cam_write_enable;
  logic          cam_write_busy;
  logic [DW-1:0] cam_compare_data;
  logic          cam_match;
  logic [AW-1:0] cam_match_addr;

  always #5 clk = ~clk;

  cam_table_mgr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CMP_LATENCY(1)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_op           (req_op),
    .req_key          (req_key),
    .resp_valid       (resp_valid),
    .resp_status      (resp_status),
    .resp_addr        (resp_addr),
    .free_count       (free_count),
    .cam_write_addr   (cam_write_addr),
    .cam_write_data   (cam_write_data),
    .cam_write_delete (cam_write_delete),
    .cam_write_enable (cam_write_enable),
    .cam_write_busy   (cam_write_busy),
    .cam_compare_data (cam_compare_data),
    .cam_match        (cam_match),
    .cam_match_addr   (cam_match_addr)
  );

  // Behavioural CAM: one-cycle registered compare, busy for busy_hold cycles after a write.
  logic [DW-1:0] cam_key [DEPTH];
  logic          cam_vld [DEPTH];
  int            busy_hold = 2;
  int            busy_cnt;
  logic          hit_c;
  logic [AW-1:0] hit_addr_c;

  always_comb begin
    hit_c      = 1'b0;
    hit_addr_c = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (cam_vld[i] && cam_key[i] == cam_compare_data) begin
        hit_c      = 1'b1;
        hit_addr_c = AW'(i);
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) cam_vld[i] <= 1'b0;
      busy_cnt       <= 0;
      cam_match      <= 1'b0;
      cam_match_addr <= '0;
    end else begin
      if (cam_write_enable) begin
        cam_vld[cam_write_addr] <= !cam_write_delete;
        cam_key[cam_write_addr] <= cam_write_data;
        busy_cnt                <= busy_hold;
      end else if (busy_cnt > 0) begin
        busy_cnt <= busy_cnt - 1;
      end
      cam_match      <= hit_c;
      cam_match_addr <= hit_addr_c;
    end
  end

  assign cam_write_busy = (busy_cnt != 0);

  typedef struct { logic [1:0] st; logic [AW-1:0] ad; } resp_t;
  typedef struct { logic [AW-1:0] ad; logic [DW-1:0] data; logic del; } wr_t;

  resp_t resp_q[$];
  wr_t   wr_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a response or a write pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (resp_valid) begin
        checks++;
        if (resp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp got status=%0d addr=%0d expected=none", resp_status, resp_addr);
        end else begin
          resp_t e;
          e = resp_q.pop_front();
          if (resp_status !== e.st || resp_addr !== e.ad) begin
            errors++;
            $display("FAIL resp got status=%0d addr=%0d expected status=%0d addr=%0d",
                     resp_status, resp_addr, e.st, e.ad);
          end else begin
            $display("resp status=%0d addr=%0d free_count=%0d", resp_status, resp_addr, free_count);
          end
        end
      end
      if (cam_write_enable) begin
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write got addr=%0d data=%0h del=%0b expected=none",
                   cam_write_addr, cam_write_data, cam_write_delete);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          if (cam_write_addr !== w.ad || cam_write_data !== w.data || cam_write_delete !== w.del) begin
            errors++;
            $display("FAIL write got addr=%0d data=%0h del=%0b expected addr=%0d data=%0h del=%0b",
                     cam_write_addr, cam_write_data, cam_write_delete, w.ad, w.data, w.del);
          end
        end
      end
    end
  end

  // Issue one request, wait for its response, then check free_count.
  // exp_delta != 0 also checks cycles from the write pulse to resp_valid.
  task automatic do_req(input logic [1:0] op, input logic [DW-1:0] key, input logic [1:0] st,
                        input logic [AW-1:0] ad, input bit wr, input int fc, input int exp_delta);
    int n, wr_n, resp_n, ready_seen;
    bit got;
    for (n = 0; n < 100 && !req_ready; n++) @(negedge clk);
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got=0 expected=1");
      return;
    end
    resp_q.push_back('{st: st, ad: ad});
    if (wr) wr_q.push_back('{ad: ad, data: key, del: (op == DEL)});
    req_valid = 1'b1;
    req_op    = op;
    req_key   = key;
    @(posedge clk);
    #1 req_valid = 1'b0;
    got = 0; wr_n = -1; resp_n = 0; ready_seen = 0;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (cam_write_enable) wr_n = n;
      if (resp_valid) begin
        got    = 1;
        resp_n = n;
        break;
      end
      if (req_ready) ready_seen++;
    end
    chk("resp_seen", 64'(got), 64'd1);
    chk("ready_low_while_busy", 64'(ready_seen), 64'd0);
    if (exp_delta != 0) chk("write_to_resp_cycles", 64'(resp_n - wr_n), 64'(exp_delta));
    @(negedge clk);
    chk("free_count", 64'(free_count), 64'(fc));
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'd0;
    req_key   = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_write_enable", 64'(cam_write_enable), 64'd0);
    chk("rst_compare_data", cam_compare_data, 64'd0);
    chk("rst_free_count", 64'(free_count), 64'd32);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);

    do_req(INS, 64'd10, OK,       5'd0, 1, 31, 0);
    do_req(INS, 64'd14, OK,       5'd1, 1, 30, 0);
    do_req(INS, 64'd10, EXISTS,   5'd0, 0, 30, 0);
    do_req(LKP, 64'd14, OK,       5'd1, 0, 30, 0);
    do_req(LKP, 64'd99, NOTFOUND, 5'd0, 0, 30, 0);
    do_req(DEL, 64'd10, OK,       5'd0, 1, 31, 0);
    do_req(INS, 64'd7,  OK,       5'd0, 1, 30, 0);
    do_req(DEL, 64'd10, NOTFOUND, 5'd0, 0, 30, 0);
    do_req(RSV, 64'd7,  OK,       5'd0, 0, 30, 0);
    do_req(DEL, 64'd7,  OK,       5'd0, 1, 31, 0);
    do_req(DEL, 64'd14, OK,       5'd1, 1, 32, 0);

    for (int i = 0; i < DEPTH; i++)
      do_req(INS, 64'(100 + i), OK, AW'(i), 1, 31 - i, 0);
    do_req(INS, 64'd200, FULL,   5'd0,  0, 0, 0);
    do_req(INS, 64'd105, EXISTS, 5'd5,  0, 0, 0);
    do_req(LKP, 64'd131, OK,     5'd31, 0, 0, 0);
    do_req(DEL, 64'd117, OK,     5'd17, 1, 1, 0);
    do_req(INS, 64'd300, OK,     5'd17, 1, 0, 0);

    busy_hold = 16;
    do_req(DEL, 64'd300, OK, 5'd17, 1, 1, 18);

    // Reset while the manager is parked in WAIT_BUSY: the response must never appear.
    wr_q.push_back('{ad: 5'd17, data: 64'd400, del: 1'b0});
    for (n = 0; n < 100 && !req_ready; n++) @(negedge clk);
    req_valid = 1'b1;
    req_op    = INS;
    req_key   = 64'd400;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (n = 0; n < 50 && !cam_write_enable; n++) @(negedge clk);
    chk("abort_write_seen", 64'(cam_write_enable), 64'd1);
    repeat (3) @(negedge clk);
    chk("abort_wait_ready", 64'(req_ready), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rst_ready", 64'(req_ready), 64'd0);
    chk("abort_rst_write_enable", 64'(cam_write_enable), 64'd0);
    @(negedge clk);
    rst       = 1'b0;
    busy_hold = 2;
    @(negedge clk);
    chk("abort_free_count", 64'(free_count), 64'd32);
    chk("abort_req_ready", 64'(req_ready), 64'd1);
    repeat (25) @(negedge clk);

    do_req(LKP, 64'd100, NOTFOUND, 5'd0, 0, 32, 0);
    do_req(INS, 64'd5,   OK,       5'd0, 1, 31, 0);

    repeat (5) @(negedge clk);
    chk("resp_queue_drained", 64'(resp_q.size()), 64'd0);
    chk("write_queue_drained", 64'(wr_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
